// File: rtl/mxn_pipeline_pkg.sv
// Shared defaults and width helpers for the MxN pipeline receive path.
package mxn_pipeline_pkg;

  localparam int unsigned M_DEFAULT = 3;
  localparam int unsigned N_DEFAULT = 4;

  // Lane FIFO depth: twice the nominal lane-1 lag.
  function automatic int unsigned depth_for(input int unsigned n);
    return 2 * n;
  endfunction

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mxn_lane_fifo.sv
// Per-lane circular FIFO; a pop in the same cycle frees a slot for a push.
module mxn_lane_fifo
  import mxn_pipeline_pkg::*;
#(
  parameter int unsigned M     = M_DEFAULT,
  parameter int unsigned DEPTH = depth_for(N_DEFAULT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           push,
  input  logic [M-1:0]                   push_data,
  input  logic                           pop,
  output logic [M-1:0]                   head_data,
  output logic [clog2(DEPTH+1)-1:0]      count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [M-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  // Status and accepted-operation decode; clr suppresses both operations.
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    do_pop    = pop && !empty && !clr;
    do_push   = push && (!full || do_pop) && !clr;
    head_data = mem[rd_ptr];
  end

  // Pointers wrap modulo DEPTH and occupancy tracks accepted operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mxn_pipeline_deskew.sv
// Re-pairs lane-0/lane-1 words by arrival order and presents them on a
// single registered valid/ready output with sticky error flags.
module mxn_pipeline_deskew
  import mxn_pipeline_pkg::*;
#(
  parameter int unsigned M     = M_DEFAULT,
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned DEPTH = depth_for(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in0_valid,
  input  logic [M-1:0] in0,
  input  logic         in1_valid,
  input  logic [M-1:0] in1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out0,
  output logic [M-1:0] out1,
  output logic         overflow,
  output logic         skew_err
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic          full0;
  logic          full1;
  logic          empty0;
  logic          empty1;
  logic [M-1:0]  head0;
  logic [M-1:0]  head1;
  logic          load_c;
  logic          push1_c;
  logic          skew_hit_c;
  logic          ovf_hit_c;

  // Pair loading, lane-1 admission and flag events. Pops remove one entry
  // from each lane, so the unmatched count is unaffected by this cycle's pop.
  always_comb begin
    load_c     = 1'b0;
    push1_c    = 1'b0;
    skew_hit_c = 1'b0;
    ovf_hit_c  = 1'b0;
    if (!clr) begin
      load_c     = !empty0 && !empty1 && (!out_valid || out_ready);
      push1_c    = in1_valid && (cnt0 > cnt1);
      skew_hit_c = in1_valid && !(cnt0 > cnt1);
      ovf_hit_c  = (in0_valid && full0 && !load_c) ||
                   (push1_c && full1 && !load_c);
    end
  end

  mxn_lane_fifo #(.M(M), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (in0_valid),
    .push_data (in0),
    .pop       (load_c),
    .head_data (head0),
    .count     (cnt0),
    .full      (full0),
    .empty     (empty0)
  );

  mxn_lane_fifo #(.M(M), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (push1_c),
    .push_data (in1),
    .pop       (load_c),
    .head_data (head1),
    .count     (cnt1),
    .full      (full1),
    .empty     (empty1)
  );

  // Output pair register: load replaces, accept without load empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out0      <= '0;
      out1      <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out0      <= '0;
      out1      <= '0;
    end else if (load_c) begin
      out_valid <= 1'b1;
      out0      <= head0;
      out1      <= head1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (ovf_hit_c)  overflow <= 1'b1;
      if (skew_hit_c) skew_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mxn_pipeline_deskew.sv
// Self-checking bench for mxn_pipeline_deskew: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_mxn_pipeline_deskew;

  localparam int unsigned M     = 3;
  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in0_valid;
  logic [M-1:0] in0;
  logic         in1_valid;
  logic [M-1:0] in1;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out0;
  logic [M-1:0] out1;
  logic         overflow;
  logic         skew_err;

  mxn_pipeline_deskew #(.M(M), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in0_valid (in0_valid),
    .in0       (in0),
    .in1_valid (in1_valid),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .overflow  (overflow),
    .skew_err  (skew_err)
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model: two lane queues plus the output pair and flags.
  logic [M-1:0] q0[$];
  logic [M-1:0] q1[$];
  logic         m_ov;
  logic [M-1:0] m_o0;
  logic [M-1:0] m_o1;
  logic         m_ovf;
  logic         m_skw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ov  = 1'b0;
    m_o0  = '0;
    m_o1  = '0;
    m_ovf = 1'b0;
    m_skw = 1'b0;
  endtask

  // One clock of the specified behaviour, applied to the model.
  task automatic model_update(input bit v0, input logic [M-1:0] d0,
                              input bit v1, input logic [M-1:0] d1,
                              input bit rdy, input bit c);
    int  unmatched;
    bit  pairing;
    if (c) begin
      model_reset();
      return;
    end
    unmatched = q0.size() - q1.size();
    pairing   = (q0.size() > 0) && (q1.size() > 0) && (!m_ov || rdy);
    if (pairing) begin
      m_o0 = q0.pop_front();
      m_o1 = q1.pop_front();
      m_ov = 1'b1;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    if (v0) begin
      if (q0.size() < DEPTH) q0.push_back(d0);
      else m_ovf = 1'b1;
    end
    if (v1) begin
      if (unmatched <= 0) m_skw = 1'b1;
      else if (q1.size() < DEPTH) q1.push_back(d1);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("model_out_valid", 32'(out_valid), 32'(m_ov));
    chk("model_out0",      32'(out0),      32'(m_o0));
    chk("model_out1",      32'(out1),      32'(m_o1));
    chk("model_overflow",  32'(overflow),  32'(m_ovf));
    chk("model_skew_err",  32'(skew_err),  32'(m_skw));
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input bit v0, input logic [M-1:0] d0,
                      input bit v1, input logic [M-1:0] d1,
                      input bit rdy, input bit c);
    in0_valid = v0;
    in0       = d0;
    in1_valid = v1;
    in1       = d1;
    out_ready = rdy;
    clr       = c;
    model_update(v0, d0, v1, d1, rdy, c);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic clear_step();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  // Words 1..5 on lane 0 at cycles 0-4, on lane 1 at cycles 4-8.
  task automatic aligned_run(input string tag, input bit bp);
    bit           ev;
    logic [M-1:0] ed;
    for (int i = 0; i < 14; i++) begin
      step(i < 5, M'(i + 1), (i >= 4) && (i < 9), M'(i - 3),
           bp ? !((i >= 5) && (i <= 8)) : 1'b1, 1'b0);
      ev = 1'b0;
      ed = '0;
      if (!bp && i >= 5 && i <= 9) begin ev = 1'b1; ed = M'(i - 4); end
      if (bp && i >= 5 && i <= 8)  begin ev = 1'b1; ed = M'(1);     end
      if (bp && i >= 9 && i <= 12) begin ev = 1'b1; ed = M'(i - 7); end
      chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
      if (ev) begin
        chk({tag, "_out0"}, 32'(out0), 32'(ed));
        chk({tag, "_out1"}, 32'(out1), 32'(ed));
      end
    end
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_skew_err"}, 32'(skew_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           lag_v [300];
    logic [M-1:0] lag_d [300];

    rst_n = 1'b0;
    clr = 1'b0; in0_valid = 1'b0; in0 = '0; in1_valid = 1'b0; in1 = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out0",      32'(out0),      32'd0);
    chk("reset_out1",      32'(out1),      32'd0);
    chk("reset_overflow",  32'(overflow),  32'd0);
    chk("reset_skew_err",  32'(skew_err),  32'd0);
    rst_n = 1'b1;

    aligned_run("aligned", 1'b0);
    clear_step();
    aligned_run("backpressure", 1'b1);

    // Overflow: ten lane-0 words into an eight-entry FIFO.
    clear_step();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, M'(i + 1), 1'b0, '0, 1'b1, 1'b0);
      if (i == 7) chk("ovf_before_9th", 32'(overflow), 32'd0);
      if (i == 8) chk("ovf_after_9th",  32'(overflow), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1, M'(i + 1), 1'b1, 1'b0);
      if (i == 1) chk("ovf_first_pair", 32'(out0), 32'd1);
    end
    repeat (3) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    // Skew error: lane-1 word with lane-0 FIFO empty.
    clear_step();
    step(1'b0, '0, 1'b1, M'(5), 1'b1, 1'b0);
    chk("skew_flag",      32'(skew_err),  32'd1);
    chk("skew_out_valid", 32'(out_valid), 32'd0);

    // Both FIFOs full with the output stalled, then push during a pair load.
    clear_step();
    for (int i = 0; i < 10; i++)
      step(i <= 8, M'(i + 1), i >= 1, M'(i), 1'b0, 1'b0);
    chk("full_no_ovf",  32'(overflow), 32'd0);
    step(1'b1, M'(7), 1'b0, '0, 1'b1, 1'b0);
    chk("fullpop_ovf",   32'(overflow),  32'd0);
    chk("fullpop_valid", 32'(out_valid), 32'd1);
    chk("fullpop_out0",  32'(out0),      32'd2);
    chk("fullpop_out1",  32'(out1),      32'd2);

    // Randomized lagged stream with random gaps and backpressure.
    clear_step();
    for (int k = 0; k < 240; k++) begin
      lag_v[k] = (k < 200) && ($urandom_range(9, 0) < 7);
      lag_d[k] = M'($urandom_range(7, 0));
      step(lag_v[k], lag_d[k],
           (k >= N) ? lag_v[k - N] : 1'b0,
           (k >= N) ? lag_d[k - N] : '0,
           $urandom_range(9, 0) < 6, 1'b0);
    end

    // Unconstrained random traffic, occasional clr, and a mid-run reset.
    for (int k = 0; k < 150; k++) begin
      step($urandom_range(1, 0) == 1, M'($urandom_range(7, 0)),
           $urandom_range(1, 0) == 1, M'($urandom_range(7, 0)),
           $urandom_range(1, 0) == 1, $urandom_range(29, 0) == 0);
      if (k == 75) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out0",  32'(out0),      32'd0);
        chk("async_rst_ovf",   32'(overflow),  32'd0);
        chk("async_rst_skew",  32'(skew_err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // Reset mid-stream, buffer three words, clr, then a clean aligned stream.
    step(1'b1, M'(3), 1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, M'(i + 4), 1'b0, '0, 1'b0, 1'b0);
    clear_step();
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_out0",  32'(out0),      32'd0);
    chk("clr_out1",  32'(out1),      32'd0);
    chk("clr_ovf",   32'(overflow),  32'd0);
    chk("clr_skew",  32'(skew_err),  32'd0);
    aligned_run("after_clr", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mxn_pipeline_deskew.md
# mxn_pipeline_deskew

Receive-side realignment block for the two-lane MxN pipeline. Lane 0 arrives N cycles ahead of lane 1 for the same logical word, so this block buffers each lane, re-pairs words by arrival order, and presents aligned {lane0, lane1} pairs on a valid/ready output with backpressure. It sits directly downstream of the MxN shift-register pipeline and reports overflow and skew violations through sticky flags.

## Interface
- M, 3: lane width in bits
- N, 4: nominal lane-1 lag in cycles
- DEPTH, 8 (2*N): entries per lane FIFO; must be ≥ N+1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: empties both FIFOs and the output register, clears sticky flags
- in0_valid  in  1  lane-0 word present this cycle
- in0  in  M  lane-0 data
- in1_valid  in  1  lane-1 word present this cycle
- in1  in  M  lane-1 data
- out_valid  out  1  aligned pair held on out0/out1
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready
- out0  out  M  lane-0 half of the pair
- out1  out  M  lane-1 half of the pair
- overflow  out  1  sticky: a push was dropped because its FIFO was full
- skew_err  out  1  sticky: a lane-1 word arrived with no unmatched lane-0 word

## Operation
- Reset values: out_valid=0, out0=0, out1=0, overflow=0, skew_err=0, both FIFOs empty, pointers 0.
- Lane FIFOs F0 and F1: circular, DEPTH entries; pointers wrap modulo DEPTH; occupancy counters are clog2(DEPTH+1) bits wide.
- Lane-1 push rule:
  - in1_valid pushes to F1 only if unmatched count (F0 count − F1 count, after this cycle's pops) > 0.
  - Otherwise the word is dropped and skew_err is set.
- Full rule:
  - A push to a full FIFO is dropped and overflow is set.
  - A pop in the same cycle frees the slot first, so the push is accepted.
- Pairing: when both FIFOs are non-empty and the output register is free, one entry is popped from each and loaded into out0/out1.
  - Output register is free when !out_valid || out_ready.
- Output register:
  - out_valid rises on load.
  - out0/out1 are held stable while out_valid && !out_ready.
  - out_valid falls after acceptance with no new load.
- clr takes priority over all pushes and pops in its cycle. Inputs presented during clr are discarded.
- Sticky flags clear only on rst_n or clr.
- No state machine beyond the FIFOs and output register. Pairing is purely by arrival order.

## Timing
- Lane-0 word at edge t and its lane-1 word at t+N → out_valid asserted after edge t+N+1, provided the output register was free.
- With out_ready held high, throughput is one pair per cycle.
- Output stage has one register: no combinational path from in0/in1 to outputs. out_ready feeds only register enables.
- Asynchronous reset mid-operation: all state returns to reset values immediately. No partial pair survives.
- Simultaneous load and accept in the same cycle: new pair replaces old, out_valid stays 1.

## Structure
- Shared package mxn_pipeline_pkg holds:
  - lane-width and lag defaults (M, N)
  - DEPTH derivation function (2*N)
  - clog2 helper used for counter and pointer widths
- One sub-module is natural: mxn_lane_fifo (parameters M, DEPTH), instantiated once per lane.
  - Ports: push, push_data, pop, head_data, count, full, empty.
  - Same-cycle pop-then-push semantics on full.
- Top level holds the unmatched-count check, the pairing/output register and the sticky flags.

## Test plan
- Aligned stream, M=3, N=4: in0 = 1,2,3,4,5 at cycles 0–4; in1 = same at cycles 4–8; out_ready=1 → pairs (1,1)…(5,5) with out_valid at cycles 5–9; no flags.
- Backpressure: as above, but out_ready=0 during cycles 5–8 → pair (1,1) held stable for 4 cycles, then (2,2)…(5,5) on consecutive cycles; nothing lost.
- Overflow, DEPTH=8: 10 lane-0 words with no lane-1 input → overflow=1 after the 9th push; F0 keeps words 1–8.
- Skew error: in1_valid at cycle 0 with F0 empty → word dropped, skew_err=1, out_valid stays 0.
- Full plus simultaneous pop: F0 and F1 full, out_ready=1, new in0 push in the same cycle as a pair load → push accepted, overflow stays 0.
- Reset/clear: rst_n low mid-stream, then clr with 3 words buffered → all outputs 0, flags 0, following aligned stream pairs correctly from the first word.
